// File: rtl/player_direction_controller.sv
// Decodes PS/2 make/break/extended sequences into per-player turn requests.
// Requests are held until the game-step tick, where legal turns are committed.
module player_direction_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       game_tick,
    input  logic [3:0] alive,
    output logic [7:0] dir,
    output logic [3:0] dir_changed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } prefix_state_t;

    localparam logic [7:0] RESET_DIR = 8'b00_10_11_01;

    prefix_state_t    state_q, state_d;
    logic [3:0][1:0]  dir_q, dir_d;
    logic [3:0][1:0]  pending_dir_q, pending_dir_d;
    logic [3:0]       pending_valid_q, pending_valid_d;
    logic [3:0]       dir_changed_q, dir_changed_d;

    logic             is_make;
    logic [4:0]       key;

    // Returns {hit, player[1:0], heading[1:0]} for a make code.
    function automatic logic [4:0] decode_key(input logic [7:0] code);
        logic [4:0] r;
        r = 5'b0;
        case (code)
            8'h1D: r = {1'b1, 2'd0, 2'd0};
            8'h23: r = {1'b1, 2'd0, 2'd1};
            8'h1B: r = {1'b1, 2'd0, 2'd2};
            8'h1C: r = {1'b1, 2'd0, 2'd3};
            8'h2C: r = {1'b1, 2'd1, 2'd0};
            8'h33: r = {1'b1, 2'd1, 2'd1};
            8'h34: r = {1'b1, 2'd1, 2'd2};
            8'h2B: r = {1'b1, 2'd1, 2'd3};
            8'h43: r = {1'b1, 2'd2, 2'd0};
            8'h4B: r = {1'b1, 2'd2, 2'd1};
            8'h42: r = {1'b1, 2'd2, 2'd2};
            8'h3B: r = {1'b1, 2'd2, 2'd3};
            8'h75: r = {1'b1, 2'd3, 2'd0};
            8'h74: r = {1'b1, 2'd3, 2'd1};
            8'h73: r = {1'b1, 2'd3, 2'd2};
            8'h6B: r = {1'b1, 2'd3, 2'd3};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    // Headings are opposite when their 2-bit codes differ by exactly 2.
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

    always_comb begin
        state_d = state_q;
        is_make = 1'b0;
        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_code == 8'hE0)      state_d = EXT;
                    else if (scan_code == 8'hF0) state_d = BRK;
                    else                         is_make = 1'b1;
                end
                EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        is_make = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK:     state_d = IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign key = decode_key(scan_code);

    always_comb begin
        dir_d           = dir_q;
        dir_changed_d   = 4'b0;
        pending_dir_d   = pending_dir_q;
        pending_valid_d = pending_valid_q;
        for (int p = 0; p < 4; p++) begin
            if (game_tick) begin
                pending_valid_d[p] = 1'b0;
                if (pending_valid_q[p] && alive[p] &&
                    !is_opposite(pending_dir_q[p], dir_q[p])) begin
                    dir_d[p]         = pending_dir_q[p];
                    dir_changed_d[p] = (pending_dir_q[p] != dir_q[p]);
                end
            end
            // Entry check uses the pre-commit heading; commit re-checks later.
            if (is_make && key[4] && (key[3:2] == 2'(p)) &&
                !is_opposite(key[1:0], dir_q[p])) begin
                pending_dir_d[p]   = key[1:0];
                pending_valid_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            dir_q           <= RESET_DIR;
            dir_changed_q   <= 4'b0;
            pending_dir_q   <= '0;
            pending_valid_q <= 4'b0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            dir_changed_q   <= dir_changed_d;
            pending_dir_q   <= pending_dir_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    assign dir         = dir_q;
    assign dir_changed = dir_changed_q;

endmodule

// File: doc/player_direction_controller.md
# player_direction_controller

Turns the PS/2 scan-code byte stream into committed headings for up to four lightbike players. It decodes make/break/extended prefixes and matches make codes against each player's fixed keyset. Requested turns are held per player and applied only on the game-step tick, with reversals rejected. It sits between the PS/2 receiver and the game-state/collision logic.

## Interface
- No parameters. Player p (0..3) always uses keyset p+1.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `scan_code`  in  8  byte from the PS/2 receiver.
- `scan_valid`  in  1  one-cycle strobe; `scan_code` is valid in that cycle.
- `game_tick`  in  1  one-cycle strobe per game step.
- `alive`  in  4  bit p=1 while player p is alive.
- `dir`  out  8  committed heading, 2 bits per player (`dir[2p+1:2p]`): 00 up, 01 right, 10 down, 11 left.
- `dir_changed`  out  4  one-cycle pulse per player when that player's `dir` takes a new value.

## Operation
- Keysets, given as up/right/down/left:
  - p0: 1D/23/1B/1C
  - p1: 2C/33/34/2B
  - p2: 43/4B/42/3B
  - p3: 75/74/73/6B, accepted with or without an E0 prefix.
- Prefix FSM: one transition per `scan_valid`.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is decoded as a make code and the FSM stays in IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is decoded as a make code, then -> IDLE.
  - BRK: any byte is discarded (key release), then -> IDLE.
  - EXT_BRK: any byte is discarded, then -> IDLE.
  - Unmatched codes, including E1, are ignored.
- Make decode: a code matches at most one player and direction.
  - Entry check: if the requested heading is the opposite of that player's current `dir`, drop it.
  - Otherwise load `pending_dir[p]` and set `pending_valid[p]`. The last accepted key before a tick wins.
- Commit on `game_tick`, for each p:
  - If `pending_valid[p]`, `alive[p]`, and `pending_dir[p]` is not opposite the current `dir[p]`: `dir[p] <= pending_dir[p]`.
  - `dir_changed[p]` pulses only if the value actually differs from the old `dir[p]`.
  - `pending_valid[p]` is cleared on every tick, whether the request committed, was rejected or belonged to a dead player.
- Dead players: `dir` is frozen; keys still set pending, which is discarded at the next tick.
- Opposite pairs: up/down, left/right. Equivalently, the 2-bit codes differ by exactly 2 (mod 4).

## Timing
- Reset values:
  - `dir` = {p3 up 00, p2 down 10, p1 left 11, p0 right 01} = 8'b00_10_11_01.
  - `dir_changed` = 0, all `pending_valid` = 0, FSM = IDLE.
- Reset in mid-sequence (e.g. after E0 or F0): the prefix is lost; the next byte is decoded from IDLE.
- A byte strobed in cycle n updates pending state at edge n+1.
  - It affects a `game_tick` in cycle n+1 or later, never one in cycle n.
- `game_tick` in cycle n gives new `dir` and a `dir_changed` pulse visible in cycle n+1; the pulse lasts exactly 1 cycle.
- `scan_valid` and `game_tick` in the same cycle:
  - The tick commits and clears the old pending request.
  - The byte's request (entry-checked against the pre-commit `dir`) becomes the new pending request for the next tick.
  - That request is re-checked against the new `dir` at commit.
- Back-to-back `scan_valid` on consecutive cycles must be handled; there is no backpressure.
- `game_tick` on consecutive cycles: the second tick commits only requests accepted after the first tick.

## Test plan
1. Reset for 2 cycles -> `dir`=8'h2D (8'b00_10_11_01), `dir_changed`=0; with no scan bytes, tick -> no change and no pulse.
2. Strobe 1D, then one cycle later a tick -> `dir[1:0]`=00 and `dir_changed`=4'b0001 for exactly one cycle. Then 1C and a tick -> p0 left (11).
3. From reset, 1C (left, opposite of p0's right) then a tick -> `dir` unchanged, `dir_changed`=0. Sequence F0,1D then a tick -> no change.
4. E0,6B then a tick -> p3 `dir`=11. E0,F0,74 then a tick -> no change. Bare 74 then a tick -> p3 stays left (74 is right, the opposite of left, so it is rejected).
5. For p1 (left): 2C then 33 (opposite, dropped) then a tick -> p1 up. With `alive[2]`=0, 43 then a tick -> p2 stays down and `dir_changed[2]`=0.
6. 1D strobed in the same cycle as a tick -> no change at that tick; a second tick later -> p0 up. E0 followed by reset, then 1B -> decoded from IDLE, p0 pending down, commits at the next tick.
